nibble_serial_tx: RTL and testbench
===================================

// Module: nibble_serial_tx
// PURPOSE
//  Parallel-in/serial-out transmitter for a 4-bit register value; the sending end of the lab serial link.
//  - Captures a nibble on a load strobe and shifts it out LSB-first on a single line.
//  - Frame is start bit (0), DATA_W data bits, stop bit (1).
//  - Sits between the board's 4-bit data registers and the external serial pin.
// PARAMETERS
//  DATA_W        4      data bits per frame (bench covers 4 only)
//  CLKS_PER_BIT  10416  clk cycles per serial bit (100 MHz / 9600 baud); legal range >= 2
// PORTS
//  clk    in   1       single system clock, rising edge
//  reset  in   1       synchronous, active-high reset
//  din    in   DATA_W  parallel data, sampled only on an accepted load
//  load   in   1       request to send din; accepted when load && ready at a rising edge
//  ready  out  1       1 = idle, a load will be accepted this cycle
//  tx     out  1       serial line, idles high
//  done   out  1       one-cycle pulse on the last clk of the stop bit
// BEHAVIOUR
//  Reset: state=IDLE, tx=1, ready=1, done=0, shift reg=0, bit/clk counters=0.
//  - Reset overrides everything, including a mid-frame transmission.
//  - After a mid-frame reset, tx=1 on the cycle following the reset edge; the partial frame is abandoned.
//  States: IDLE -> START -> DATA -> STOP -> IDLE.
//  - IDLE:  tx=1, ready=1. On load&&ready: latch din into shift reg, clear counters, go to START.
//  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//  - DATA:  tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right at each bit boundary.
//           After DATA_W bits, go to STOP.
//  - STOP:  tx=1 for CLKS_PER_BIT cycles. done=1 on the final cycle; then go to IDLE.
//  Latency and length:
//  - Load accepted at edge N: tx=0 from cycle N+1.
//  - Full frame is (DATA_W+2)*CLKS_PER_BIT cycles.
//  - ready=0 from cycle N+1 through the done cycle; ready=1 the cycle after done.
//  Boundary conditions:
//  - load while ready=0: ignored, no queueing; din changes mid-frame have no effect.
//  - Back-to-back: load held high re-triggers in the first IDLE cycle after done.
//    The next start bit begins the following cycle, so the line is idle-high for exactly 1 cycle between frames.
//  - load and reset at the same edge: reset wins, the load is dropped.
//  - Clock counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps to 0 at a bit boundary.
//    It is held at 0 in IDLE.
//  - Bit index: width $clog2(DATA_W+1); never exceeds DATA_W-1 in DATA.
//  - tx is driven from a register (glitch-free); no combinational path from load to tx.
// STRUCTURE
//  - Package nibble_tx_pkg: typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
//    localparams for the start-bit and stop-bit levels (1'b0, 1'b1).
//  - Sub-module baud_tick_gen #(CLKS_PER_BIT):
//    inputs clk, reset, en; output tick, a one-cycle pulse on count==CLKS_PER_BIT-1.
//    When en=0, it clears its count to 0.
//  - Top module: FSM, shift register, bit counter, output registers.
// TESTING (bench uses CLKS_PER_BIT=4, DATA_W=4)
//  1. Reset, then idle 20 cycles -> tx=1, ready=1, done=0 throughout.
//  2. din=4'b1011, load for 1 cycle -> tx holds each level 4 cycles in order 0,1,1,0,1,1;
//     done pulses at cycle 24 after load; ready=1 at cycle 25.
//  3. During the frame from test 2, at cycle 6 drive din=4'b0000 and load=1 -> serial data still 1,1,0,1;
//     no second frame.
//  4. load held high with din=4'hA then 4'h5 -> two frames; data bits 0,1,0,1 then 1,0,1,0;
//     exactly 1 idle-high cycle between the stop bit and the next start bit.
//  5. Assert reset at cycle 10 of a frame with din=4'hF -> tx=1 and ready=1 the next cycle; no done pulse;
//     a new load sends a clean frame.
//  6. Assert load and reset at the same edge -> stays IDLE, tx=1, no start bit.

Source files
------------

// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and line levels for the nibble serial transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nibble_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Serial line levels for the framing bits.
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/nibble_serial_tx_baud_tick_gen.sv
// Bit-period timer: pulses tick on the last clk of every CLKS_PER_BIT-cycle bit period.
// Latency: tick is combinational from the count; the first tick comes CLKS_PER_BIT cycles after en rises.
// Backpressure: none; en=0 holds the count at 0.
// Ports: clk, reset (sync, active-high), en (run/clear), tick (one-cycle pulse).
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nibble_serial_tx.sv
// Parallel-in/serial-out transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Latency: load accepted at edge N drives the start bit from cycle N+1; frame is (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: ready=0 while a frame is in flight; loads seen then are dropped, never queued.
// Ports: clk, reset (sync, active-high), din/load (parallel request), ready, tx (serial line), done (end-of-frame pulse).
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [BW-1:0]     bit_idx, bit_nxt;
    logic              tx_nxt;
    logic              tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .en   (state != IDLE),
        .tick (tick)
    );

    assign ready = (state == IDLE);
    assign done  = (state == STOP) && tick;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        bit_nxt   = bit_idx;
        case (state)
            IDLE: begin
                if (load) begin
                    shift_nxt = din;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = shift >> 1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_idx + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // tx is registered from the level of the state being entered, so the
        // line changes exactly at the bit boundary with no combinational path.
        tx_nxt = STOP_LVL;
        case (state_nxt)
            START:   tx_nxt = START_LVL;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = STOP_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= STOP_LVL;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_nxt;
            tx      <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx with CLKS_PER_BIT=4, DATA_W=4.
// Stimulus pushes the expected per-cycle {tx, ready, done}; a monitor pops and compares each cycle.
// Summary line reports comparisons made and failures.
module tb_nibble_serial_tx;

    localparam int CPB       = 4;
    localparam int DW        = 4;
    localparam int FRAME_LEN = (DW + 2) * CPB;

    typedef struct {
        logic  tx;
        logic  rdy;
        logic  dn;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] din = 4'h0;
    logic       load = 1'b0;
    logic       ready;
    logic       tx;
    logic       done;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_seen  = 0;
    bit   stim_done = 1'b0;

    nibble_serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .load (load),
        .ready(ready),
        .tx   (tx),
        .done (done)
    );

    always #5 clk = ~clk;

    // Expected line level in frame cycle i (1-based): 4 cycles each of start, d0..d3, stop.
    function automatic logic exp_tx(input logic [3:0] nib, input int i);
        int seg;
        seg = (i - 1) / CPB;
        if (seg == 0) return 1'b0;
        else if (seg <= DW) return nib[seg-1];
        else return 1'b1;
    endfunction

    // One cycle: after the edge, drive inputs for the next edge and record
    // what the outputs must show during this cycle.
    task automatic cyc(input logic rst, input logic ld, input logic [3:0] d,
                       input logic etx, input logic erdy, input logic edn,
                       input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        load  = ld;
        din   = d;
        e.tx  = etx;
        e.rdy = erdy;
        e.dn  = edn;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic ld, input logic [3:0] d, input string tag);
        for (int k = 0; k < n; k++) cyc(1'b0, ld, d, 1'b1, 1'b1, 1'b0, tag);
    endtask

    task automatic frame(input logic [3:0] nib, input int first, input int last,
                         input logic ld, input logic [3:0] d, input string tag);
        for (int i = first; i <= last; i++)
            cyc(1'b0, ld, d, exp_tx(nib, i), 1'b0, (i == FRAME_LEN), tag);
    endtask

    // Stimulus
    initial begin
        // Test 1: reset then 20 idle cycles.
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, "t1_reset");
        idle(20, 1'b0, 4'h0, "t1_idle");

        // Tests 2/3: 4'b1011 frame; cycles 6..10 try to reload with 0.
        idle(1, 1'b1, 4'b1011, "t2_load");
        frame(4'b1011, 1, 5, 1'b0, 4'b1011, "t2_frame");
        frame(4'b1011, 6, 10, 1'b1, 4'b0000, "t3_busy_load");
        frame(4'b1011, 11, FRAME_LEN, 1'b0, 4'b0000, "t2_frame");
        idle(5, 1'b0, 4'h0, "t3_no_second");

        // Test 4: load held high, A then 5, one idle cycle between frames.
        idle(1, 1'b1, 4'hA, "t4_load");
        frame(4'hA, 1, 11, 1'b1, 4'hA, "t4_frame_a");
        frame(4'hA, 12, FRAME_LEN, 1'b1, 4'h5, "t4_frame_a");
        idle(1, 1'b1, 4'h5, "t4_gap");
        frame(4'h5, 1, FRAME_LEN, 1'b0, 4'h5, "t4_frame_5");
        idle(3, 1'b0, 4'h0, "t4_idle");

        // Test 5: reset at frame cycle 10, then a clean frame.
        idle(1, 1'b1, 4'hF, "t5_load");
        frame(4'hF, 1, 9, 1'b0, 4'hF, "t5_frame");
        cyc(1'b1, 1'b0, 4'hF, exp_tx(4'hF, 10), 1'b0, 1'b0, "t5_frame");
        idle(6, 1'b0, 4'hF, "t5_after_rst");
        idle(1, 1'b1, 4'b0110, "t5_reload");
        frame(4'b0110, 1, FRAME_LEN, 1'b0, 4'b0110, "t5_clean");
        idle(2, 1'b0, 4'h0, "t5_idle");

        // Test 6: load and reset at the same edge.
        cyc(1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, "t6_both");
        idle(6, 1'b0, 4'h3, "t6_no_start");

        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        while (!stim_done) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_seen++;
                n_tests++;
                if (tx !== e.tx || ready !== e.rdy || done !== e.dn) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got tx=%b ready=%b done=%b, want tx=%b ready=%b done=%b",
                             e.tag, n_seen, tx, ready, done, e.tx, e.rdy, e.dn);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
